// File: rtl/sm_fixed_pkg.sv
// Shared definitions for the sign-magnitude fixed-point datapath.
// Word layout: bit N is the sign, bits N-1:0 are the magnitude with FRAC
// fractional bits (default Q7.8 in a 16-bit word).
// Optional build macro: SM_DIVIDE_ROUND_EN adds the ROUND state to the
// divider state enum.
package sm_fixed_pkg;

    localparam int SM_N    = 15;
    localparam int SM_FRAC = 8;

    typedef logic [SM_N:0] sm_word_t;

    localparam logic [SM_N-1:0] SM_MAX_MAG = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
`ifdef SM_DIVIDE_ROUND_EN
        ST_ROUND,
`endif
        ST_DONE
    } sm_div_state_t;

    // Magnitude field of a sign-magnitude word; negative zero maps to 0.
    function automatic logic [SM_N-1:0] sm_abs(input sm_word_t w);
        return w[SM_N-1:0];
    endfunction

endpackage

// File: rtl/sm_div_step.sv
// One restoring-division iteration (combinational).
// Ports:
//   rem      - current partial remainder, always < divisor
//   bit_in   - next dividend bit shifted into the remainder
//   divisor  - divisor magnitude
//   rem_next - updated partial remainder
//   q_bit    - quotient bit produced by this iteration
module sm_div_step #(
    parameter int N = 15
) (
    input  logic [N-1:0] rem,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] diff;

    assign shifted = {rem, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // Both candidates are below the divisor, so they fit in N bits.
    assign rem_next = q_bit ? N'(diff) : N'(shifted);

endmodule

// File: rtl/sm_divide_seq.sv
// Sequential sign-magnitude fixed-point divider, one quotient bit per clock.
// quotient = sign(A^B) * floor((|A| << FRAC) / |B|), saturated to 2^N-1.
// Optional build macro: SM_DIVIDE_ROUND_EN adds a ROUND cycle that rounds
// the magnitude half-up instead of truncating.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - request a division (sampled only in IDLE)
//   dividend, divisor - sign-magnitude operands, sampled with start
//   busy              - operation in progress (CALC/ROUND/DONE)
//   done              - one-cycle pulse when quotient is valid
//   quotient          - sign-magnitude result, held until next completion
//   div_by_zero       - set with done when |divisor| == 0
module sm_divide_seq
    import sm_fixed_pkg::*;
#(
    parameter int N    = SM_N,
    parameter int FRAC = SM_FRAC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N:0]   dividend,
    input  logic [N:0]   divisor,
    output logic         busy,
    output logic         done,
    output logic [N:0]   quotient,
    output logic         div_by_zero
);

    localparam int QW = N + FRAC;
    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);
    localparam logic [N-1:0]  MAX_MAG  = '1;
`ifdef SM_DIVIDE_ROUND_EN
    // The final quotient bit lands in qacc before ROUND reads it.
    localparam int QAW = QW;
`else
    // The final quotient bit is taken straight from the step logic.
    localparam int QAW = QW - 1;
`endif

    sm_div_state_t state, state_nxt;

    logic [N-1:0]   mag_a, mag_b, rem;
    logic           sign;
    logic [QAW-1:0] qacc;
    logic [CW-1:0]  cnt;

    logic           load, step, res_load, res_dbz, res_sign;
    logic [N-1:0]   res_mag;
    logic [QW-1:0]  stream, q_final;
    logic [N-1:0]   step_rem, mag_sat;
    logic           step_q;

    // Dividend stream: |A| followed by FRAC zeros, consumed MSB first.
    assign stream = {mag_a, {FRAC{1'b0}}};

    sm_div_step #(.N(N)) u_step (
        .rem      (rem),
        .bit_in   (stream[cnt]),
        .divisor  (mag_b),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

`ifdef SM_DIVIDE_ROUND_EN
    assign q_final = qacc;
`else
    assign q_final = {qacc, step_q};
`endif

    assign mag_sat = (|q_final[QW-1:N]) ? MAX_MAG : q_final[N-1:0];

`ifdef SM_DIVIDE_ROUND_EN
    logic         round_up;
    logic [N-1:0] mag_rnd;
    // Half-up: remainder/|B| >= 1/2  <=>  2*rem >= |B|.
    assign round_up = ({rem, 1'b0} >= {1'b0, mag_b});
    assign mag_rnd  = (round_up && mag_sat != MAX_MAG) ? mag_sat + 1'b1 : mag_sat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        res_load  = 1'b0;
        res_dbz   = 1'b0;
        res_mag   = mag_sat;
        res_sign  = sign;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (divisor[N-1:0] == '0) begin
                        // Divide by zero skips CALC; sign comes from the
                        // inputs because the sign register loads this edge.
                        state_nxt = ST_DONE;
                        res_load  = 1'b1;
                        res_dbz   = 1'b1;
                        res_mag   = MAX_MAG;
                        res_sign  = dividend[N] ^ divisor[N];
                    end else begin
                        state_nxt = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == '0) begin
`ifdef SM_DIVIDE_ROUND_EN
                    state_nxt = ST_ROUND;
`else
                    state_nxt = ST_DONE;
                    res_load  = 1'b1;
`endif
                end
            end
`ifdef SM_DIVIDE_ROUND_EN
            ST_ROUND: begin
                busy      = 1'b1;
                state_nxt = ST_DONE;
                res_load  = 1'b1;
                res_mag   = mag_rnd;
            end
`endif
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a       <= '0;
            mag_b       <= '0;
            sign        <= 1'b0;
            rem         <= '0;
            qacc        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (load) begin
                mag_a <= dividend[N-1:0];
                mag_b <= divisor[N-1:0];
                sign  <= dividend[N] ^ divisor[N];
                rem   <= '0;
                qacc  <= '0;
                cnt   <= CNT_LAST;
            end else if (step) begin
                rem  <= step_rem;
                qacc <= {qacc[QAW-2:0], step_q};
                cnt  <= cnt - CW'(1);
            end
            if (res_load) begin
                // A zero magnitude never carries a sign.
                quotient    <= {res_sign & (|res_mag), res_mag};
                div_by_zero <= res_dbz;
            end
        end
    end

endmodule

// File: tb/tb_sm_divide_seq.sv
// Directed-vector bench for sm_divide_seq (default N=15, FRAC=8).
// Latency is counted with the start edge as 1: done seen right after that
// edge is latency 1, after 23 further edges is latency 24.
module tb_sm_divide_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient;

    int n_chk = 0;
    int n_err = 0;

`ifdef SM_DIVIDE_ROUND_EN
    localparam int          LAT    = 25;
    localparam logic [15:0] Q_RND  = 16'h00AB;
`else
    localparam int          LAT    = 24;
    localparam logic [15:0] Q_RND  = 16'h00AA;
`endif

    sm_divide_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One division; noise=1 pulses start mid-run and during DONE.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_q, input logic exp_dbz,
                           input int exp_lat, input bit noise);
        int lat;
        bit busy_ok;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        // Operands change after sampling; the result must not follow them.
        dividend = 16'h5555;
        divisor  = 16'h0003;
        lat      = 1;
        busy_ok  = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (noise && lat == 5) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_run"}, busy_ok, 1'b1);
        chk({tag, "_busy_done"}, busy, 1'b1);
        chk({tag, "_q"}, quotient, exp_q);
        chk({tag, "_dbz"}, div_by_zero, exp_dbz);
        if (noise) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_q_hold"}, quotient, exp_q);
    endtask

    initial begin
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q", quotient, 16'h0000);
        chk("rst_dbz", div_by_zero, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_div("basic",    16'h04E0, 16'h0340, 16'h0180, 1'b0, LAT, 1'b0);
        run_div("neg_a",    16'h84E0, 16'h0340, 16'h8180, 1'b0, LAT, 1'b0);
        run_div("neg_ab",   16'h84E0, 16'h8340, 16'h0180, 1'b0, LAT, 1'b0);
        run_div("negzero",  16'h8000, 16'h0340, 16'h0000, 1'b0, LAT, 1'b0);
        run_div("sat_pos",  16'h7F00, 16'h0001, 16'h7FFF, 1'b0, LAT, 1'b0);
        run_div("sat_neg",  16'hFF00, 16'h0001, 16'hFFFF, 1'b0, LAT, 1'b0);
        run_div("dbz",      16'h8100, 16'h0000, 16'hFFFF, 1'b1, 1,   1'b0);
        run_div("dbz_clr",  16'h04E0, 16'h0340, 16'h0180, 1'b0, LAT, 1'b0);
        run_div("dbz_nz",   16'h0100, 16'h8000, 16'hFFFF, 1'b1, 1,   1'b0);
        run_div("round",    16'h0200, 16'h0300, Q_RND,    1'b0, LAT, 1'b0);
        run_div("small",    16'h0100, 16'h0200, 16'h0080, 1'b0, LAT, 1'b0);
        run_div("noise",    16'h84E0, 16'h0340, 16'h8180, 1'b0, LAT, 1'b1);

        // Reset in the middle of a division.
        begin
            bit saw_done;
            dividend = 16'h0200;
            divisor  = 16'h0300;
            start    = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (9) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            chk("midrst_busy", busy, 1'b0);
            chk("midrst_done", done, 1'b0);
            chk("midrst_q", quotient, 16'h0000);
            chk("midrst_dbz", div_by_zero, 1'b0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            saw_done = 1'b0;
            repeat (30) begin
                @(posedge clk); #1;
                if (done || busy) saw_done = 1'b1;
            end
            chk("midrst_no_done", saw_done, 1'b0);
        end
        run_div("after_rst", 16'h04E0, 16'h0340, 16'h0180, 1'b0, LAT, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sm_divide_seq.md
Name: sm_divide_seq

Overview:
- Sequential sign-magnitude fixed-point divider; the inverse operation of the datapath's combinational sign-magnitude multiplier.
- Word format: 1 sign bit (MSB) plus an N-bit magnitude with FRAC fractional bits. Default is a 16-bit Q7.8 word.
- Restoring division, one quotient bit per clock, with a start/done handshake.
- Used by the filter coefficient/normalisation path, where a result every ~25 cycles is sufficient.

Parameters:
- N, 15, magnitude width; the word is N+1 bits.
- FRAC, 8, number of fractional bits in the magnitude.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  N+1  sign-magnitude dividend A; sampled with start.
- divisor  input  N+1  sign-magnitude divisor B; sampled with start.
- busy  output  1  high while a division is in progress (CALC or DONE).
- done  output  1  one-cycle pulse when quotient is valid.
- quotient  output  N+1  sign-magnitude A/B; holds until the next completion.
- div_by_zero  output  1  set with done when |B|==0; holds with quotient.

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0, done=0, quotient=0, div_by_zero=0; internal registers cleared.
- States: IDLE, CALC, DONE.
- IDLE + start=1 at edge k:
  - latch |A|, |B| and sign = A[N]^B[N].
  - if |B|==0: go to DONE.
  - else: clear remainder, counter=N+FRAC-1, go to CALC.
  - busy=1 from edge k.
- CALC, one restoring step per cycle:
  - rem' = {rem, next dividend bit}, where the dividend stream is |A| followed by FRAC zeros, MSB first.
  - if rem' >= |B|: rem = rem' - |B| and shift in quotient bit 1; else rem = rem' and shift in 0.
  - the step at counter 0 is the last; then go to DONE.
  - exactly N+FRAC (23) CALC cycles.
- Magnitude result: Q = floor((|A| << FRAC) / |B|), held in an N+FRAC-bit register.
  - if any bit above N-1 is set, saturate the magnitude to 2^N-1 (0x7FFF).
- DONE (one cycle): done=1, busy=1; quotient and div_by_zero register on entry (same edge done rises); next edge returns to IDLE with busy=0, done=0.
- Divide by zero: magnitude 2^N-1, sign = A[N]^B[N], div_by_zero=1.
- Zero magnitude result (including |A|==0): sign bit forced to 0; no negative zero is emitted.
- Negative-zero inputs (0x8000) are treated as magnitude 0.
- Latency from start edge k: done rises at k+24 in the normal case, or k+1 on divide by zero.
- start is ignored while busy, including in the DONE cycle; operand changes after sampling have no effect.
- quotient and div_by_zero change only on entry to DONE or on reset.
- Reset deasserted mid-operation resumes from IDLE; a reset pulse mid-division produces no done.

Optional Feature:
- Macro SM_DIVIDE_ROUND_EN.
- Defined: after the last CALC step, one extra ROUND cycle before DONE. If 2*rem >= |B|, the magnitude is incremented by 1, saturating at 2^N-1. Normal latency becomes k+25; the divide-by-zero path is unchanged.
- Undefined: truncation toward zero, no ROUND state.

Decomposition:
- Package sm_fixed_pkg:
  - N and FRAC default constants.
  - typedef sm_word_t (N+1 bits).
  - constant SM_MAX_MAG (2^N-1).
  - state enum (IDLE, CALC, [ROUND], DONE).
  - function sm_abs returning the magnitude field.
- One sub-module, sm_div_step: combinational single restoring iteration.
  - inputs: rem, next bit, divisor.
  - outputs: new rem, quotient bit.
  - instantiated once in the CALC datapath.

Test Plan:
- A=0x04E0, B=0x0340, start one cycle -> done at k+24; quotient=0x0180; div_by_zero=0; busy high k..k+24.
- Signs: A=0x84E0, B=0x0340 -> 0x8180. A=0x84E0, B=0x8340 -> 0x0180. A=0x8000, B=0x0340 -> 0x0000 (sign cleared).
- Saturation: A=0x7F00, B=0x0001 -> 0x7FFF. A=0xFF00, B=0x0001 -> 0xFFFF. div_by_zero=0 in both.
- Divide by zero: A=0x8100, B=0x0000 -> done at k+1; quotient=0x FFFF; div_by_zero=1. Next normal op clears the flag.
- Rounding: A=0x0200, B=0x0300 -> 0x00AA without SM_DIVIDE_ROUND_EN; 0x00AB with it, and done at k+25.
- Robustness:
  - start pulsed while busy -> ignored, and the result matches the first operands.
  - rst_n asserted at k+10 -> busy, done and quotient go to 0 immediately; no done pulse.
  - a new start after release works normally.
